// File: rtl/c17_bist_ctrl_if.sv
// Pattern/response and status bundle between the c17 BIST sequencer and its harness.
interface c17_bist_ctrl_if;
    logic       start;
    logic [4:0] pi;
    logic [1:0] po;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;
    logic [7:0] pat_idx;

    modport master (
        input  start,
        input  po,
        output pi,
        output busy,
        output done,
        output pass,
        output signature,
        output pat_idx
    );

    modport slave (
        output start,
        output po,
        input  pi,
        input  busy,
        input  done,
        input  pass,
        input  signature,
        input  pat_idx
    );
endinterface

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for c17: LFSR patterns, programmable settle, 8-bit MISR compaction
// and a registered golden-signature compare.
module c17_bist_ctrl #(
    parameter int unsigned NUM_PAT    = 31,
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [4:0]  SEED       = 5'b00001,
    parameter logic [7:0]  GOLDEN     = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    c17_bist_ctrl_if.master bus
);

    // An all-zero seed would lock the LFSR, so it is mapped to 00001.
    localparam logic [4:0] SEED_EFF    = (SEED == 5'b00000) ? 5'b00001 : SEED;
    localparam logic [7:0] LAST_IDX    = 8'(NUM_PAT - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state_q;
    logic [4:0] pi_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] sig_q;
    logic [7:0] idx_q;
    logic [3:0] wait_q;

    logic [4:0] pi_d;
    logic [7:0] sig_d;

    // x^5 + x^3 + 1, maximal length (period 31)
    function automatic logic [4:0] lfsr_next(input logic [4:0] p);
        return {p[3:0], p[4] ^ p[2]};
    endfunction

    function automatic logic [7:0] misr_next(input logic [7:0] s, input logic [1:0] r);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b0, r};
    endfunction

    assign pi_d  = lfsr_next(pi_q);
    assign sig_d = misr_next(sig_q, bus.po);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pi_q    <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            sig_q   <= 8'd0;
            idx_q   <= 8'd0;
            wait_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        pi_q    <= SEED_EFF;
                        sig_q   <= 8'd0;
                        pass_q  <= 1'b0;
                        idx_q   <= 8'd0;
                        wait_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    wait_q <= wait_q + 4'd1;
                    if (wait_q == SETTLE_LAST) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    sig_q <= sig_d;
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        pi_q    <= pi_d;
                        idx_q   <= idx_q + 8'd1;
                        wait_q  <= 4'd0;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    // sig_q already holds the final capture here
                    done_q  <= 1'b0;
                    pass_q  <= (sig_q == GOLDEN);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pi        = pi_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
    assign bus.pat_idx   = idx_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl: several parameterisations beside a behavioural c17.
module tb_c17_bist_ctrl;

    // pi bit map {N7,N6,N3,N2,N1}; returns {N23,N22}
    function automatic logic [1:0] c17(input logic [4:0] p);
        logic n10, n11, n16, n19;
        n10 = ~(p[0] & p[2]);
        n11 = ~(p[2] & p[3]);
        n16 = ~(p[1] & n11);
        n19 = ~(n11 & p[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [7:0] ref_sig(input logic stuck22);
        logic [4:0] p;
        logic [7:0] s;
        logic [1:0] r;
        p = 5'b00001;
        s = 8'h00;
        for (int k = 0; k < 31; k++) begin
            r = c17(p);
            if (stuck22) r[0] = 1'b0;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b0, r};
            p = {p[3:0], p[4] ^ p[2]};
        end
        return s;
    endfunction

    localparam logic [7:0] GOLD_REF   = ref_sig(1'b0);
    localparam logic [7:0] GOLD_STUCK = ref_sig(1'b1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    c17_bist_ctrl_if ifa ();
    c17_bist_ctrl_if ifb ();
    c17_bist_ctrl_if ifc ();
    c17_bist_ctrl_if ifd ();
    c17_bist_ctrl_if ife ();

    assign ifa.po = c17(ifa.pi);
    assign ifb.po = 2'b01;
    assign ifc.po = 2'b01;
    assign ifd.po = c17(ifd.pi);
    assign ife.po = c17(ife.pi) & 2'b10;

    c17_bist_ctrl #(.GOLDEN(GOLD_REF)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    c17_bist_ctrl #(.NUM_PAT(2), .GOLDEN(8'h03)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    c17_bist_ctrl #(.NUM_PAT(2), .GOLDEN(8'h00)) u_c (.clk(clk), .rst(rst), .bus(ifc));
    c17_bist_ctrl #(.NUM_PAT(4), .SEED(5'b00000)) u_d (.clk(clk), .rst(rst), .bus(ifd));
    c17_bist_ctrl #(.GOLDEN(GOLD_REF)) u_e (.clk(clk), .rst(rst), .bus(ife));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        bit seen;
        rst = 1'b1;
        tick(2);
        nvec++; if (ifa.pi !== 5'd0) begin nerr++; $display("FAIL reset_pi got %h want 00", ifa.pi); end
        nvec++; if (ifa.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", ifa.busy); end
        nvec++; if (ifa.done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", ifa.done); end
        nvec++; if (ifa.pass !== 1'b0) begin nerr++; $display("FAIL reset_pass got %b want 0", ifa.pass); end
        nvec++; if (ifa.signature !== 8'h00) begin nerr++; $display("FAIL reset_sig got %h want 00", ifa.signature); end
        nvec++; if (ifa.pat_idx !== 8'h00) begin nerr++; $display("FAIL reset_idx got %h want 00", ifa.pat_idx); end
        rst = 1'b0;
        ifa.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
        tick(9);
        nvec++; if (ifa.busy !== 1'b1) begin nerr++; $display("FAIL midrun_busy got %b want 1", ifa.busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        nvec++; if (ifa.busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got %b want 0", ifa.busy); end
        nvec++; if (ifa.pi !== 5'd0) begin nerr++; $display("FAIL abort_pi got %h want 00", ifa.pi); end
        nvec++; if (ifa.signature !== 8'h00) begin nerr++; $display("FAIL abort_sig got %h want 00", ifa.signature); end
        nvec++; if (ifa.pat_idx !== 8'h00) begin nerr++; $display("FAIL abort_idx got %h want 00", ifa.pat_idx); end
        seen = 1'b0;
        for (int t = 0; t < 120; t++) begin
            if (ifa.done === 1'b1 || ifa.busy === 1'b1) seen = 1'b1;
            tick(1);
        end
        nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL abort_quiet got activity=%b want 0", seen); end
    endtask

    task automatic test_pattern_seq;
        logic [4:0] exp_pi [5];
        bit got_done;
        exp_pi[0] = 5'h01; exp_pi[1] = 5'h02; exp_pi[2] = 5'h04; exp_pi[3] = 5'h09; exp_pi[4] = 5'h12;
        ifa.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                nvec++;
                if (ifa.pi !== exp_pi[k] || ifa.pat_idx !== 8'(k)) begin
                    nerr++;
                    $display("FAIL pattern_%0d_cyc%0d got pi=%h idx=%0d want pi=%h idx=%0d", k, c, ifa.pi, ifa.pat_idx, exp_pi[k], k);
                end
                tick(1);
            end
        end
        got_done = 1'b0;
        for (int t = 0; t < 200 && !got_done; t++) begin
            if (ifa.done === 1'b1) got_done = 1'b1;
            else tick(1);
        end
        nvec++; if (!got_done) begin nerr++; $display("FAIL pattern_run_end got no done want done"); end
        tick(2);
    endtask

    task automatic test_timing;
        int bc, dt, last_busy;
        logic [7:0] idx_at_done;
        bc = 0; dt = -1; last_busy = -1; idx_at_done = 8'hxx;
        ifa.start = 1'b1;
        for (int t = 1; t <= 200 && dt < 0; t++) begin
            tick(1);
            ifa.start = 1'b0;
            if (ifa.busy === 1'b1) begin bc++; last_busy = t; end
            if (ifa.done === 1'b1) begin dt = t; idx_at_done = ifa.pat_idx; end
        end
        nvec++; if (dt < 0) begin nerr++; $display("FAIL timing_done got timeout want done"); end
        nvec++; if (bc != 93) begin nerr++; $display("FAIL timing_busy_len got %0d want 93", bc); end
        nvec++; if (dt != last_busy + 1) begin nerr++; $display("FAIL timing_done_pos got %0d want %0d", dt, last_busy + 1); end
        nvec++; if (idx_at_done !== 8'd30) begin nerr++; $display("FAIL timing_final_idx got %0d want 30", idx_at_done); end
        tick(1);
        nvec++; if (ifa.done !== 1'b0) begin nerr++; $display("FAIL timing_done_pulse got %b want 0", ifa.done); end
        nvec++; if (ifa.pass !== 1'b1) begin nerr++; $display("FAIL timing_pass got %b want 1", ifa.pass); end
        nvec++; if (ifa.signature !== GOLD_REF) begin nerr++; $display("FAIL timing_sig got %h want %h", ifa.signature, GOLD_REF); end
        tick(1);
    endtask

    task automatic test_misr;
        bit got_done;
        ifb.start = 1'b1;
        ifc.start = 1'b1;
        tick(1);
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        tick(2);
        nvec++; if (ifb.signature !== 8'h00) begin nerr++; $display("FAIL misr_pre got %h want 00", ifb.signature); end
        tick(1);
        nvec++; if (ifb.signature !== 8'h01 || ifb.pat_idx !== 8'd1) begin nerr++; $display("FAIL misr_first got sig=%h idx=%0d want sig=01 idx=1", ifb.signature, ifb.pat_idx); end
        got_done = 1'b0;
        for (int t = 0; t < 20 && !got_done; t++) begin
            if (ifb.done === 1'b1) got_done = 1'b1;
            else tick(1);
        end
        nvec++; if (!got_done) begin nerr++; $display("FAIL misr_done got timeout want done"); end
        nvec++; if (ifb.signature !== 8'h03) begin nerr++; $display("FAIL misr_final_b got %h want 03", ifb.signature); end
        nvec++; if (ifc.signature !== 8'h03) begin nerr++; $display("FAIL misr_final_c got %h want 03", ifc.signature); end
        nvec++; if (ifb.pass !== 1'b0) begin nerr++; $display("FAIL misr_pass_early got %b want 0", ifb.pass); end
        tick(1);
        nvec++; if (ifb.pass !== 1'b1) begin nerr++; $display("FAIL misr_pass_golden03 got %b want 1", ifb.pass); end
        nvec++; if (ifc.pass !== 1'b0) begin nerr++; $display("FAIL misr_pass_golden00 got %b want 0", ifc.pass); end
        tick(3);
        nvec++; if (ifb.pass !== 1'b1 || ifb.signature !== 8'h03) begin nerr++; $display("FAIL misr_hold got pass=%b sig=%h want pass=1 sig=03", ifb.pass, ifb.signature); end
    endtask

    task automatic test_start_robust;
        int bc, dc, dt;
        logic b95, b96;
        bc = 0; dt = -1;
        ifa.start = 1'b1;
        for (int t = 1; t <= 200 && dt < 0; t++) begin
            tick(1);
            ifa.start = (t == 5);
            if (ifa.busy === 1'b1) bc++;
            if (ifa.done === 1'b1) dt = t;
        end
        nvec++; if (bc != 93 || dt != 94) begin nerr++; $display("FAIL start_in_settle got busy=%0d done_at=%0d want busy=93 done_at=94", bc, dt); end
        tick(2);
        bc = 0; dc = 0; b95 = 1'bx; b96 = 1'bx;
        ifa.start = 1'b1;
        for (int t = 1; t <= 96; t++) begin
            tick(1);
            if (t <= 95 && ifa.busy === 1'b1) bc++;
            if (ifa.done === 1'b1) dc++;
            if (t == 95) b95 = ifa.busy;
            if (t == 96) b96 = ifa.busy;
        end
        nvec++; if (bc != 93 || dc != 1) begin nerr++; $display("FAIL start_held_run got busy=%0d dones=%0d want busy=93 dones=1", bc, dc); end
        nvec++; if (b95 !== 1'b0 || b96 !== 1'b1) begin nerr++; $display("FAIL start_held_restart got busy95=%b busy96=%b want 0 1", b95, b96); end
        ifa.start = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        ifd.start = 1'b1;
        tick(1);
        ifd.start = 1'b0;
        nvec++; if (ifd.pi !== 5'h01 || ifd.busy !== 1'b1) begin nerr++; $display("FAIL seed_zero got pi=%h busy=%b want pi=01 busy=1", ifd.pi, ifd.busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_golden;
        bit got_done;
        ifa.start = 1'b1;
        ife.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
        ife.start = 1'b0;
        got_done = 1'b0;
        for (int t = 0; t < 200 && !got_done; t++) begin
            if (ifa.done === 1'b1) got_done = 1'b1;
            else tick(1);
        end
        nvec++; if (!got_done || ife.done !== 1'b1) begin nerr++; $display("FAIL golden_done got a=%b e=%b want 1 1", got_done, ife.done); end
        tick(1);
        nvec++; if (ifa.signature !== GOLD_REF || ifa.pass !== 1'b1) begin nerr++; $display("FAIL golden_good got sig=%h pass=%b want sig=%h pass=1", ifa.signature, ifa.pass, GOLD_REF); end
        nvec++; if (ife.signature !== GOLD_STUCK) begin nerr++; $display("FAIL golden_stuck_sig got %h want %h", ife.signature, GOLD_STUCK); end
        nvec++; if (ife.signature === ifa.signature || ife.pass !== 1'b0) begin nerr++; $display("FAIL golden_stuck_detect got sig=%h pass=%b want sig!=%h pass=0", ife.signature, ife.pass, ifa.signature); end
    endtask

    initial begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        ifd.start = 1'b0;
        ife.start = 1'b0;
        test_reset();
        test_pattern_seq();
        test_timing();
        test_misr();
        test_start_robust();
        test_golden();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
Built-in self-test sequencer for the c17 combinational netlist. It generates pseudo-random 5-bit input patterns with an LFSR and drives them onto c17 inputs N1/N2/N3/N6/N7. After each pattern it waits a programmable number of settle cycles, then compacts the N22/N23 responses into an 8-bit MISR signature. At the end of the run it compares the signature against a golden value and reports pass/fail. It sits beside the c17 instance in the lab test harness and gives timing-closed pattern application for STA correlation runs.

Parameters:
NUM_PAT, 31, number of patterns applied per run (1..255)
SETTLE_CYC, 2, clock cycles each pattern is held before capture (1..15)
SEED, 5'b00001, LFSR start pattern; 5'b00000 is illegal and is silently replaced by 5'b00001
GOLDEN, 8'h00, expected final MISR signature

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle run request; honoured only in IDLE
pi  out  5  pattern to c17, bit map {N7,N6,N3,N2,N1}; registered
po  in  2  c17 responses {N23,N22}
busy  out  1  high in SETTLE and CAPTURE
done  out  1  one-cycle pulse when the run completes
pass  out  1  signature==GOLDEN, registered in DONE, held until next start
signature  out  8  MISR value, held after DONE until next start
pat_idx  out  8  index of the pattern currently applied

Behaviour:
- Reset (rst=1 at clk edge, any state): state=IDLE, pi=0, busy=0, done=0, pass=0, signature=0, pat_idx=0, internal wait_cnt=0. Reset mid-run aborts with no done pulse.
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE, start=1: pi<=SEED (or 00001 if SEED=0), signature<=0, pass<=0, pat_idx<=0, wait_cnt<=0, go to SETTLE. start=0: stay, all outputs hold.
- SETTLE: wait_cnt++. When wait_cnt==SETTLE_CYC-1, go to CAPTURE. The pattern is therefore stable on pi for SETTLE_CYC cycles before the capture edge.
- CAPTURE (one cycle): signature<={s[6:0], s[7]^s[5]^s[4]^s[3]} ^ {6'b0, po}. po is sampled at the CAPTURE clock edge.
  - If pat_idx==NUM_PAT-1: go to DONE; pi holds.
  - Else: pi<={pi[3:0], pi[4]^pi[2]} (x^5+x^3+1, maximal, period 31), pat_idx++, wait_cnt<=0, go to SETTLE.
- DONE (one cycle): done=1, pass<=(signature==GOLDEN) (uses the final value), go to IDLE. pass becomes visible the cycle after done.
- start while busy or in DONE: ignored, no queueing.
- busy duration: exactly NUM_PAT*(SETTLE_CYC+1) cycles. With defaults this is 93.
- The LFSR sequence from 00001 is 00001, 00010, 00100, 01001, 10010, ...; it never reaches 00000.
- NUM_PAT>31 wraps the LFSR and repeats patterns. This is legal.
- All outputs are registered; there are no combinational paths from po or start to any output.

Test Plan:
- Reset mid-run: start, then rst=1 at cycle 10 -> next cycle state=IDLE, busy=0, pi=0, signature=0, no done pulse.
- Pattern sequence: SEED=00001, real c17 attached -> pi = 01h, 02h, 04h, 09h, 12h on successive patterns, each held exactly 2 cycles before CAPTURE. Pattern 0 gives po=00.
- Timing, defaults: start -> busy high for exactly 93 cycles, done pulses once the cycle after busy falls, pat_idx final=30.
- MISR arithmetic: NUM_PAT=2, stub po=2'b01 constant -> signature=8'h01 after the first capture, 8'h03 at DONE; GOLDEN=8'h03 gives pass=1; GOLDEN=8'h00 gives pass=0.
- Start robustness: start held high for the whole run -> exactly one run, then an immediate restart from IDLE. A start pulse during SETTLE does not extend the run. SEED=0 -> first pi=01h.
- Golden run: real c17, defaults, GOLDEN set to the reference-model signature -> pass=1. Force N22 stuck-at-0 in c17 -> signature differs, pass=0.
